// File: rtl/fpmult_share_ctrl.sv
// fpmult_share_ctrl
// Shares one fixed-latency FP multiplier pipeline between two requesters.
// Each cycle a round-robin arbiter grants at most one requester. A tag pipeline
// records which port owns each in-flight operation, and each result is routed
// back to that port.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_issue_en                   0 blocks new grants; in-flight work still drains
//   i_reqN_valid / o_reqN_ready  per-port handshake (ready is combinational)
//   i_reqN_a, i_reqN_b           per-port operands
//   o_mul_valid, o_mul_a/b       registered issue to the multiplier
//   i_mul_result, i_mul_flags    multiplier outputs, valid LAT cycles after issue
//   o_respN_valid                registered one-cycle response pulse per port
//   o_resp_result, o_resp_flags  shared response data, qualified by o_respN_valid
//   o_busy                       registered; high while anything is issued or in flight
module fpmult_share_ctrl #(
    parameter int LAT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_issue_en,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    output logic        o_mul_valid,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    input  logic [31:0] i_mul_result,
    input  logic [4:0]  i_mul_flags,
    output logic        o_resp0_valid,
    output logic        o_resp1_valid,
    output logic [31:0] o_resp_result,
    output logic [4:0]  o_resp_flags,
    output logic        o_busy
);

    // r_last = 1 means port 1 was granted most recently, so port 0 wins the next tie.
    logic        r_last;
    logic        r_mul_valid;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [LAT:0] r_tag_vld;
    logic [LAT:0] r_tag_own;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic [31:0] r_resp_result;
    logic [4:0]  r_resp_flags;
    logic        r_busy;

    logic w_grant0;
    logic w_grant1;
    logic w_hs;

    // A port wins when the other is idle, or on a tie when it was not granted last.
    assign w_grant0 = i_issue_en & i_req0_valid & (~i_req1_valid | r_last);
    assign w_grant1 = i_issue_en & i_req1_valid & (~i_req0_valid | ~r_last);
    assign w_hs     = w_grant0 | w_grant1;

    assign o_req0_ready  = w_grant0;
    assign o_req1_ready  = w_grant1;
    assign o_mul_valid   = r_mul_valid;
    assign o_mul_a       = r_mul_a;
    assign o_mul_b       = r_mul_b;
    assign o_resp0_valid = r_resp0_valid;
    assign o_resp1_valid = r_resp1_valid;
    assign o_resp_result = r_resp_result;
    assign o_resp_flags  = r_resp_flags;
    assign o_busy        = r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last        <= 1'b1;
            r_mul_valid   <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_tag_vld     <= '0;
            r_tag_own     <= '0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_mul_valid <= w_hs;
            if (w_hs) begin
                r_last  <= w_grant1;
                r_mul_a <= w_grant1 ? i_req1_a : i_req0_a;
                r_mul_b <= w_grant1 ? i_req1_b : i_req0_b;
            end

            // Stage 0 lines up with the issue registers; stage LAT lines up
            // with the cycle in which the multiplier output is valid.
            r_tag_vld <= {r_tag_vld[LAT-1:0], w_hs};
            r_tag_own <= {r_tag_own[LAT-1:0], w_grant1};

            if (r_tag_vld[LAT]) begin
                r_resp_result <= i_mul_result;
                r_resp_flags  <= i_mul_flags;
                r_resp0_valid <= ~r_tag_own[LAT];
                r_resp1_valid <= r_tag_own[LAT];
            end else begin
                r_resp0_valid <= 1'b0;
                r_resp1_valid <= 1'b0;
            end

            // The response register stage adds one more cycle after the last tag stage.
            r_busy <= r_mul_valid | (|r_tag_vld);
        end
    end

endmodule

// File: tb/tb_fpmult_share_ctrl.sv
module tb_fpmult_share_ctrl;
    localparam int LAT = 4;
    localparam int N   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_en = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [31:0] mul_result = '0;
    logic [4:0]  mul_flags = '0;
    logic        rdy0, rdy1, mul_valid, resp0_valid, resp1_valid, busy;
    logic [31:0] mul_a, mul_b, resp_result;
    logic [4:0]  resp_flags;

    fpmult_share_ctrl #(.LAT(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_issue_en(issue_en),
        .i_req0_valid(v0), .i_req1_valid(v1),
        .o_req0_ready(rdy0), .o_req1_ready(rdy1),
        .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
        .o_mul_valid(mul_valid), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_result(mul_result), .i_mul_flags(mul_flags),
        .o_resp0_valid(resp0_valid), .o_resp1_valid(resp1_valid),
        .o_resp_result(resp_result), .o_resp_flags(resp_flags),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Multiplier stub: a deterministic function of the operands, with the real
    // product for 2.0*3.0 so the directed case sees a true IEEE value.
    function automatic logic [31:0] stub_res(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'd1;
    endfunction

    function automatic logic [4:0] stub_flg(input logic [31:0] b);
        return b[4:0];
    endfunction

    bit          st_v[N];
    logic [31:0] st_a[N];
    logic [31:0] st_b[N];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc >= LAT && st_v[cyc-LAT]) begin
            mul_result = stub_res(st_a[cyc-LAT], st_b[cyc-LAT]);
            mul_flags  = stub_flg(st_b[cyc-LAT]);
        end else begin
            mul_result = 32'hDEAD_0000 ^ 32'(cyc);
            mul_flags  = 5'b11111 ^ 5'(cyc);
        end
    end

    // Reference model: a timeline of expected events, indexed by cycle.
    bit          mdl_init = 1'b0;
    bit          mdl_last = 1'b1;
    bit          e_mv[N];
    logic [31:0] e_ma[N], e_mb[N];
    bit          e_rv[N];
    bit          e_rp[N];
    logic [31:0] e_rr[N];
    logic [4:0]  e_rf[N];
    bit          e_busy[N];
    logic [31:0] h_ma = '0, h_mb = '0, h_rr = '0;
    logic [4:0]  h_rf = '0;
    bit          m_g0, m_g1;
    logic [31:0] m_a, m_b;

    always @(negedge clk) begin
        st_v[cyc] = mul_valid;
        st_a[cyc] = mul_a;
        st_b[cyc] = mul_b;
        if (mdl_init) begin
            m_g0 = issue_en & v0 & (~v1 | mdl_last);
            m_g1 = issue_en & v1 & (~v0 | ~mdl_last);
            chk("ready0", 32'(rdy0), 32'(m_g0));
            chk("ready1", 32'(rdy1), 32'(m_g1));
            chk("mul_valid", 32'(mul_valid), 32'(e_mv[cyc]));
            if (e_mv[cyc]) begin
                h_ma = e_ma[cyc];
                h_mb = e_mb[cyc];
            end
            chk("mul_a", mul_a, h_ma);
            chk("mul_b", mul_b, h_mb);
            chk("resp0_valid", 32'(resp0_valid), 32'(e_rv[cyc] & ~e_rp[cyc]));
            chk("resp1_valid", 32'(resp1_valid), 32'(e_rv[cyc] & e_rp[cyc]));
            if (e_rv[cyc]) begin
                h_rr = e_rr[cyc];
                h_rf = e_rf[cyc];
            end
            chk("resp_result", resp_result, h_rr);
            chk("resp_flags", 32'(resp_flags), 32'(h_rf));
            chk("busy", 32'(busy), 32'(e_busy[cyc]));
            if (!rst && (m_g0 || m_g1)) begin
                m_a = m_g1 ? a1 : a0;
                m_b = m_g1 ? b1 : b0;
                e_mv[cyc+1]       = 1'b1;
                e_ma[cyc+1]       = m_a;
                e_mb[cyc+1]       = m_b;
                e_rv[cyc+LAT+2]   = 1'b1;
                e_rp[cyc+LAT+2]   = m_g1;
                e_rr[cyc+LAT+2]   = stub_res(m_a, m_b);
                e_rf[cyc+LAT+2]   = stub_flg(m_b);
                for (int k = 2; k <= LAT + 2; k++) e_busy[cyc+k] = 1'b1;
                mdl_last = m_g1;
            end
        end
        if (rst) begin
            for (int i = cyc + 1; i < N; i++) begin
                e_mv[i] = 1'b0;
                e_rv[i] = 1'b0;
                e_busy[i] = 1'b0;
            end
            h_ma = '0; h_mb = '0; h_rr = '0; h_rf = '0;
            mdl_last = 1'b1;
            mdl_init = 1'b1;
        end
    end

    // Response log for the directed literal checks.
    int         rq_port[$];
    int         rq_cyc[$];
    logic [4:0] rq_flg[$];

    always @(negedge clk) begin
        if (resp0_valid || resp1_valid) begin
            rq_port.push_back(resp1_valid ? 1 : 0);
            rq_cyc.push_back(cyc);
            rq_flg.push_back(resp_flags);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    int gq[$];
    int r0, cnt;

    initial begin
        wait_cyc(3);
        rst = 1'b0;

        // Single port: 2.0 * 3.0 handshaked in cycle 5.
        wait_cyc(5);
        a0 = 32'h4000_0000; b0 = 32'h4040_0000; v0 = 1'b1;
        @(negedge clk);
        chk("sp_ready0", 32'(rdy0), 32'd1);
        tick();
        v0 = 1'b0;
        @(negedge clk);
        chk("sp_mul_valid", 32'(mul_valid), 32'd1);
        chk("sp_mul_a", mul_a, 32'h4000_0000);
        chk("sp_mul_b", mul_b, 32'h4040_0000);
        for (int c = 7; c <= 12; c++) begin
            wait_cyc(c);
            @(negedge clk);
            chk("sp_resp0", 32'(resp0_valid), (c == 11) ? 32'd1 : 32'd0);
            chk("sp_resp1", 32'(resp1_valid), 32'd0);
            if (c == 11) chk("sp_result", resp_result, 32'h40C0_0000);
        end

        // Contention for 6 cycles straight out of reset; port 1 ops raise flag 00100.
        wait_cyc(14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a0 = 32'h1000_0000; b0 = 32'h2000_0000;
        a1 = 32'h3000_0000; b1 = 32'h4000_0004;
        v0 = 1'b1; v1 = 1'b1;
        r0 = rq_port.size();
        repeat (6) begin
            @(negedge clk);
            gq.push_back(rdy0 ? 0 : (rdy1 ? 1 : 9));
            tick();
            if (gq[gq.size()-1] == 0) a0 = a0 + 32'd1;
            else if (gq[gq.size()-1] == 1) a1 = a1 + 32'd1;
        end
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 6; i++) chk("cont_grant", 32'(gq[i]), 32'(i % 2));
        wait_cyc(30);
        chk("cont_nresp", 32'(rq_port.size() - r0), 32'd6);
        for (int i = 0; i < 6 && r0 + i < rq_port.size(); i++) begin
            chk("cont_port", 32'(rq_port[r0+i]), 32'(i % 2));
            chk("cont_cycle", 32'(rq_cyc[r0+i]), 32'(21 + i));
            chk("cont_flags", 32'(rq_flg[r0+i]), (i % 2) ? 32'd4 : 32'd0);
        end

        // issue_en low for 3 cycles with both ports valid; last grant was port 1.
        issue_en = 1'b0; v0 = 1'b1; v1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ien_ready0", 32'(rdy0), 32'd0);
            chk("ien_ready1", 32'(rdy1), 32'd0);
            tick();
        end
        issue_en = 1'b1;
        @(negedge clk);
        chk("ien_resume0", 32'(rdy0), 32'd1);
        chk("ien_resume1", 32'(rdy1), 32'd0);
        tick();
        v0 = 1'b0; v1 = 1'b0;

        // Reset mid-flight: three ops, last grant to port 0, reset 2 cycles after.
        wait_cyc(40);
        v1 = 1'b1;
        tick();
        v1 = 1'b0; v0 = 1'b1;
        tick();
        tick();
        v0 = 1'b0;
        wait_cyc(44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chk("rst_tie0", 32'(rdy0), 32'd1);
        chk("rst_tie1", 32'(rdy1), 32'd0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        wait_cyc(51);
        cnt = 0;
        foreach (rq_cyc[i]) if (rq_cyc[i] >= 44 && rq_cyc[i] <= 50) cnt++;
        chk("rst_no_resp", 32'(cnt), 32'd0);

        // Drain: port 1 issues 60..63, busy falls at 63+LAT+3.
        wait_cyc(60);
        v1 = 1'b1;
        wait_cyc(64);
        v1 = 1'b0;
        wait_cyc(63 + LAT + 2);
        @(negedge clk);
        chk("drain_busy_hi", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        chk("drain_busy_lo", 32'(busy), 32'd0);

        wait_cyc(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
